axi_registers_burst: RTL and testbench
======================================

Name: axi_registers_burst

Overview:
- Parametrised AXI3 slave-to-register-file bridge; successor to the single-beat register bridge.
- Adds FIXED/INCR bursts up to 16 beats, byte write strobes, configurable register-file read latency, and SLVERR for out-of-range accesses.
- Sits between the PS AXI GP port and a register file.
- Read and write channels are independent and may run simultaneously.

Parameters:
AW, 4, register index width; word address = axaddr[AW+1:2]
NREGS, 16, number of implemented registers; index >= NREGS is out of range
IDW, 12, AXI ID width
RD_LATENCY, 1, cycles from rm_rd assertion to valid rm_rdata (1..4)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
s_awvalid/s_awready  in/out  1  write address handshake
s_awid  in  IDW  write ID
s_awaddr  in  32  byte address
s_awlen  in  4  beats-1
s_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_wvalid/s_wready  in/out  1  write data handshake
s_wdata  in  32  write data
s_wstrb  in  4  byte enables
s_wlast  in  1  last write beat
s_bvalid/s_bready  out/in  1  write response handshake
s_bid  out  IDW  response ID
s_bresp  out  2  write response
s_arvalid/s_arready  in/out  1  read address handshake
s_arid  in  IDW  read ID
s_araddr  in  32  byte address
s_arlen  in  4  beats-1
s_arburst  in  2  burst type
s_rvalid/s_rready  out/in  1  read data handshake
s_rid  out  IDW  read ID
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rlast  out  1  last read beat
rm_wr  out  1  register write strobe
rm_waddr  out  AW  write index
rm_wdata  out  32  write data
rm_wstrb  out  4  byte enables
rm_rd  out  1  register read strobe
rm_raddr  out  AW  read index
rm_rdata  in  32  register read data

Behaviour:
- All handshake outputs are registered.
- While reset is high:
  - all valid/ready outputs, rm_wr and rm_rd are 0.
  - bresp, rresp and rlast are 0; rdata, bid and rid are 0.
- awready and arready go to 1 on the first cycle after reset falls.
- Reset mid-burst: the transaction is dropped and no response is issued.
- Range check is done per beat:
  - out of range if axaddr[31:AW+2] != 0 or index >= NREGS.
  - the beat index counter is AW+1 bits wide; a carry out of AW bits makes that and all later beats out of range (no wrap).
- Address update: INCR increments the index after each beat; FIXED holds it; WRAP is treated as INCR.
- Write FSM has states W_ADDR, W_DATA, W_RESP.
  - W_ADDR: awready=1. On AW handshake, latch id/index/len/burst, clear the error flag, go to W_DATA. wready rises the next cycle.
  - W_DATA: wready stays 1 for the whole burst.
    - Each W handshake: if the beat is in range, rm_wr=1 combinationally that cycle, with rm_waddr = current index and wdata/wstrb passed through. If out of range, the error flag is set and no write occurs.
    - The burst ends on beat count awlen+1, not on wlast.
    - wlast must be 1 on exactly the final beat; any mismatch sets the error flag.
    - After the final beat, wready=0, bvalid=1, go to W_RESP.
  - W_RESP: bvalid held until bready. bresp = SLVERR (2'b10) if the error flag is set, else OKAY. On handshake go to W_ADDR with awready=1 the next cycle.
- Read FSM has states R_ADDR, R_ISSUE, R_WAIT, R_DATA.
  - R_ADDR: arready=1. On AR handshake, latch id/index/len/burst, go to R_ISSUE.
  - R_ISSUE: rm_rd=1 for one cycle with rm_raddr = current index. Go to R_WAIT.
  - R_WAIT: count RD_LATENCY cycles after the rm_rd cycle, then capture rm_rdata; an out-of-range beat captures 0 instead. Set rvalid=1 and rresp per beat, then go to R_DATA.
  - R_DATA: rvalid, rdata, rresp and rlast held stable until rready. rlast=1 only on beat arlen+1. On handshake, return to R_ISSUE if beats remain (next rm_rd the following cycle), else R_ADDR.
- Latency: AR handshake to first rvalid is RD_LATENCY+2 cycles. One read beat is in flight at a time.
- Simultaneous: rm_wr and rm_rd may assert in the same cycle to any indices. Ordering between channels is not guaranteed.

Decomposition:
- Package axi_reg_pkg holds:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - burst constants BURST_FIXED/INCR/WRAP.
  - wstate_t and rstate_t enums.
- Sub-module axi_reg_addr_gen holds the index counter, beat counter, last-beat flag and range check. It is instantiated once per channel.

Test Plan:
- Single write index 3 (awaddr 0x0C, awlen 0, wdata 0xDEADBEEF, wstrb 0xF) then read it back -> rm_wr one cycle at index 3; bresp OKAY; rdata 0xDEADBEEF with rlast=1 and rvalid exactly RD_LATENCY+2 cycles after AR handshake.
- INCR write awaddr 0x08 awlen 3, wstrb 0x3, with wvalid gaps -> rm_wr at indices 2,3,4,5 with rm_wstrb 0x3; one bresp OKAY with correct bid.
- FIXED read araddr 0x10 arlen 2, rready low 3 cycles on beat 2 -> 3 beats from index 4; data held stable under stall; rlast only on beat 3.
- NREGS=6, INCR read araddr 0x10 arlen 3 -> beats 0,1 OKAY; beats 2,3 SLVERR with rdata 0. Write to 0x1000 -> no rm_wr, bresp SLVERR.
- wlast on beat 2 of 4, and a separate burst with wlast missing on the final beat -> burst ends after 4 beats in both cases; bresp SLVERR.
- Concurrent 4-beat write and 4-beat read started the same cycle, then reset asserted mid-burst -> both complete correctly when run without reset; after reset, all outputs 0, no stale bvalid/rvalid, awready/arready 1 the cycle after reset falls.

Source files
------------

// File: rtl/axi_reg_pkg.sv
// axi_reg_pkg: response/burst encodings and channel FSM states for the AXI register bridge
package axi_reg_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_ADDR, R_ISSUE, R_WAIT, R_DATA} rstate_t;
endpackage

// File: rtl/axi_reg_addr_gen.sv
// axi_reg_addr_gen: per-channel register index, beat counter, last-beat flag and range check
module axi_reg_addr_gen
  import axi_reg_pkg::*;
#(
  parameter int AW = 4,
  parameter int NREGS = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [31:0]   addr,
  input  logic [3:0]    len,
  input  logic [1:0]    burst,
  input  logic          step,
  output logic [AW-1:0] idx,
  output logic          in_range,
  output logic          last
);
  localparam logic [AW:0] NR = (AW+1)'(NREGS);
  logic [AW:0] cur;
  logic [3:0] beat, len_q;
  logic fixed, hi;
  logic unused_lsb;
  assign unused_lsb = ^addr[1:0];
  // the extra index bit is sticky so a burst never wraps back into range
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= '0;
      beat <= '0;
      len_q <= '0;
      fixed <= 1'b0;
      hi <= 1'b0;
    end else if (load) begin
      cur <= {1'b0, addr[AW+1:2]};
      beat <= '0;
      len_q <= len;
      fixed <= burst == BURST_FIXED;
      hi <= |addr[31:AW+2];
    end else if (step) begin
      beat <= beat + 4'd1;
      cur <= (fixed || cur[AW]) ? cur : cur + 1'b1;
    end
  end
  assign idx = cur[AW-1:0];
  assign in_range = !hi && cur < NR;
  assign last = beat == len_q;
endmodule

// File: rtl/axi_registers_burst.sv
// axi_registers_burst: AXI3 slave bridging FIXED/INCR bursts onto a register file
module axi_registers_burst
  import axi_reg_pkg::*;
#(
  parameter int AW = 4,
  parameter int NREGS = 16,
  parameter int IDW = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_awvalid,
  output logic           s_awready,
  input  logic [IDW-1:0] s_awid,
  input  logic [31:0]    s_awaddr,
  input  logic [3:0]     s_awlen,
  input  logic [1:0]     s_awburst,
  input  logic           s_wvalid,
  output logic           s_wready,
  input  logic [31:0]    s_wdata,
  input  logic [3:0]     s_wstrb,
  input  logic           s_wlast,
  output logic           s_bvalid,
  input  logic           s_bready,
  output logic [IDW-1:0] s_bid,
  output logic [1:0]     s_bresp,
  input  logic           s_arvalid,
  output logic           s_arready,
  input  logic [IDW-1:0] s_arid,
  input  logic [31:0]    s_araddr,
  input  logic [3:0]     s_arlen,
  input  logic [1:0]     s_arburst,
  output logic           s_rvalid,
  input  logic           s_rready,
  output logic [IDW-1:0] s_rid,
  output logic [31:0]    s_rdata,
  output logic [1:0]     s_rresp,
  output logic           s_rlast,
  output logic           rm_wr,
  output logic [AW-1:0]  rm_waddr,
  output logic [31:0]    rm_wdata,
  output logic [3:0]     rm_wstrb,
  output logic           rm_rd,
  output logic [AW-1:0]  rm_raddr,
  input  logic [31:0]    rm_rdata
);
  localparam logic [1:0] LW = 2'(RD_LATENCY - 1);
  wstate_t ws, ws_n;
  rstate_t rs, rs_n;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic w_in, w_last, r_in, r_last, werr, beat_err, capture;
  logic [1:0] rcnt;
  assign aw_hs = s_awvalid && s_awready;
  assign w_hs = s_wvalid && s_wready;
  assign b_hs = s_bvalid && s_bready;
  assign ar_hs = s_arvalid && s_arready;
  assign r_hs = s_rvalid && s_rready;
  assign capture = rs == R_WAIT && rcnt == LW;
  assign beat_err = !w_in || (s_wlast != w_last);
  axi_reg_addr_gen #(.AW(AW), .NREGS(NREGS)) u_wgen (
    .clk(clk), .reset(reset), .load(aw_hs), .addr(s_awaddr), .len(s_awlen),
    .burst(s_awburst), .step(w_hs), .idx(rm_waddr), .in_range(w_in), .last(w_last)
  );
  axi_reg_addr_gen #(.AW(AW), .NREGS(NREGS)) u_rgen (
    .clk(clk), .reset(reset), .load(ar_hs), .addr(s_araddr), .len(s_arlen),
    .burst(s_arburst), .step(r_hs), .idx(rm_raddr), .in_range(r_in), .last(r_last)
  );
  assign rm_wr = w_hs && w_in;
  assign rm_wdata = s_wdata;
  assign rm_wstrb = s_wstrb;
  assign rm_rd = rs == R_ISSUE;
  // handshakes are mutually exclusive by state, so a flat priority chain suffices
  always_comb begin
    ws_n = aw_hs ? W_DATA : (w_hs && w_last) ? W_RESP : b_hs ? W_ADDR : ws;
    rs_n = ar_hs ? R_ISSUE : rs == R_ISSUE ? R_WAIT : capture ? R_DATA :
           r_hs ? (r_last ? R_ADDR : R_ISSUE) : rs;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ws <= W_ADDR;
      rs <= R_ADDR;
      s_awready <= 1'b0;
      s_wready <= 1'b0;
      s_bvalid <= 1'b0;
      s_arready <= 1'b0;
      s_rvalid <= 1'b0;
      s_bid <= '0;
      s_bresp <= RESP_OKAY;
      s_rid <= '0;
      s_rdata <= '0;
      s_rresp <= RESP_OKAY;
      s_rlast <= 1'b0;
      werr <= 1'b0;
      rcnt <= '0;
    end else begin
      ws <= ws_n;
      rs <= rs_n;
      s_awready <= ws_n == W_ADDR;
      s_wready <= ws_n == W_DATA;
      s_bvalid <= ws_n == W_RESP;
      s_arready <= rs_n == R_ADDR;
      s_rvalid <= rs_n == R_DATA;
      werr <= aw_hs ? 1'b0 : werr || (w_hs && beat_err);
      rcnt <= rs == R_WAIT ? rcnt + 2'd1 : 2'd0;
      if (aw_hs) s_bid <= s_awid;
      if (w_hs && w_last) s_bresp <= (werr || beat_err) ? RESP_SLVERR : RESP_OKAY;
      if (ar_hs) s_rid <= s_arid;
      if (capture) begin
        s_rdata <= r_in ? rm_rdata : '0;
        s_rresp <= r_in ? RESP_OKAY : RESP_SLVERR;
        s_rlast <= r_last;
      end
    end
  end
endmodule

// File: tb/tb_axi_registers_burst.sv
// tb_axi_registers_burst: directed stimulus with queue scoreboard and negedge monitor
module tb_axi_registers_burst;
  import axi_reg_pkg::*;
  localparam int AW = 4, NREGS = 6, IDW = 12, RDL = 2;
  logic clk = 0, reset = 1;
  logic s_awvalid = 0, s_awready, s_wvalid = 0, s_wready, s_wlast = 0, s_bvalid, s_bready = 1;
  logic [IDW-1:0] s_awid = 0, s_bid, s_arid = 0, s_rid;
  logic [31:0] s_awaddr = 0, s_wdata = 0, s_araddr = 0, s_rdata, rm_wdata, rm_rdata;
  logic [3:0] s_awlen = 0, s_wstrb = 0, s_arlen = 0, rm_wstrb;
  logic [1:0] s_awburst = 0, s_arburst = 0, s_bresp, s_rresp;
  logic s_arvalid = 0, s_arready, s_rvalid, s_rready = 1, s_rlast, rm_wr, rm_rd;
  logic [AW-1:0] rm_waddr, rm_raddr;
  always #5 clk = ~clk;

  axi_registers_burst #(.AW(AW), .NREGS(NREGS), .IDW(IDW), .RD_LATENCY(RDL)) dut (
    .clk(clk), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .rm_wr(rm_wr), .rm_waddr(rm_waddr), .rm_wdata(rm_wdata), .rm_wstrb(rm_wstrb),
    .rm_rd(rm_rd), .rm_raddr(rm_raddr), .rm_rdata(rm_rdata)
  );

  logic [31:0] regs [16];
  logic [31:0] pipe [RDL];
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 16; i++) regs[i] <= 32'hA5A50000 | 32'(i);
    else if (rm_wr) for (int b = 0; b < 4; b++) if (rm_wstrb[b]) regs[rm_waddr][8*b+:8] <= rm_wdata[8*b+:8];
    pipe[0] <= regs[rm_raddr];
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end
  assign rm_rdata = pipe[RDL-1];

  typedef struct packed {logic [3:0] idx; logic [31:0] d; logic [3:0] s;} wr_t;
  typedef struct packed {logic [IDW-1:0] id; logic [1:0] resp;} b_t;
  typedef struct packed {logic [IDW-1:0] id; logic [31:0] d; logic [1:0] resp; logic last;} r_t;
  wr_t exp_wr[$];
  logic [3:0] exp_ra[$];
  b_t exp_b[$];
  r_t exp_r[$];
  wr_t ew;
  b_t eb;
  r_t er, held;
  logic [3:0] ea;
  logic mon_en = 0, held_v = 0, lat_pend = 0;
  int cyc = 0, ar_cyc = 0, checks = 0, passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic miss(input string name);
    checks++;
    $display("FAIL %s: event with no expected entry or timeout", name);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) if (mon_en) begin
    if (rm_wr) begin
      if (exp_wr.size() == 0) miss("rm_wr");
      else begin ew = exp_wr.pop_front(); chk("rm_wr", {rm_waddr, rm_wdata, rm_wstrb}, ew); end
    end
    if (rm_rd) begin
      if (exp_ra.size() == 0) miss("rm_rd");
      else begin ea = exp_ra.pop_front(); chk("rm_raddr", rm_raddr, ea); end
    end
    if (s_bvalid && s_bready) begin
      if (exp_b.size() == 0) miss("bresp");
      else begin eb = exp_b.pop_front(); chk("bresp", {s_bid, s_bresp}, eb); end
    end
    if (s_rvalid && s_rready) begin
      if (exp_r.size() == 0) miss("rbeat");
      else begin er = exp_r.pop_front(); chk("rbeat", {s_rid, s_rdata, s_rresp, s_rlast}, er); end
    end
    if (held_v && s_rvalid) chk("r_hold", {s_rid, s_rdata, s_rresp, s_rlast}, held);
    held_v = s_rvalid && !s_rready;
    held = {s_rid, s_rdata, s_rresp, s_rlast};
    if (s_rvalid && lat_pend) begin chk("rd_latency", 64'(cyc - ar_cyc), 64'(RDL + 2)); lat_pend = 0; end
    if (s_arvalid && s_arready) begin ar_cyc = cyc; lat_pend = 1; end
  end

  task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                          input int gap, input int lastpos);
    int t;
    s_awvalid = 1; s_awid = id; s_awaddr = addr; s_awlen = len; s_awburst = burst;
    t = 0;
    do @(negedge clk); while (!s_awready && ++t < 100);
    if (t >= 100) miss("aw_timeout");
    @(posedge clk); #1 s_awvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      repeat (gap) begin @(posedge clk); #1; end
      s_wvalid = 1; s_wdata = base + 32'(b); s_wstrb = strb; s_wlast = (b == lastpos);
      t = 0;
      do @(negedge clk); while (!s_wready && ++t < 100);
      if (t >= 100) miss("w_timeout");
      @(posedge clk); #1 s_wvalid = 0; s_wlast = 0;
    end
    t = 0;
    do @(negedge clk); while (!s_bvalid && ++t < 100);
    if (t >= 100) miss("b_timeout");
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input int stall_beat);
    int t;
    s_arvalid = 1; s_arid = id; s_araddr = addr; s_arlen = len; s_arburst = burst;
    t = 0;
    do @(negedge clk); while (!s_arready && ++t < 100);
    if (t >= 100) miss("ar_timeout");
    @(posedge clk); #1 s_arvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == stall_beat) begin
        s_rready = 0;
        t = 0;
        do @(negedge clk); while (!s_rvalid && ++t < 100);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 s_rready = 1;
      end
      t = 0;
      do @(negedge clk); while (!s_rvalid && ++t < 100);
      if (t >= 100) miss("r_timeout");
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, "_ctrl"}, {s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp, s_rlast, rm_wr, rm_rd}, 0);
    chk({tag, "_data"}, {s_bid, s_rid, s_rdata}, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk({tag, "_fall"}, {s_awready, s_arready, s_wready, s_bvalid, s_rvalid}, 5'b00000);
    @(negedge clk);
    chk({tag, "_ready"}, {s_awready, s_arready, s_wready, s_bvalid, s_rvalid}, 5'b11000);
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_idle"}, {s_bvalid, s_rvalid, rm_wr, rm_rd}, 4'b0000);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    mon_en = 1;
    // single write then readback of index 3
    exp_wr.push_back({4'd3, 32'hDEADBEEF, 4'hF});
    exp_b.push_back({12'h005, RESP_OKAY});
    do_write(12'h005, 32'h0C, 4'd0, BURST_INCR, 32'hDEADBEEF, 4'hF, 0, 0);
    exp_ra.push_back(4'd3);
    exp_r.push_back({12'h006, 32'hDEADBEEF, RESP_OKAY, 1'b1});
    do_read(12'h006, 32'h0C, 4'd0, BURST_INCR, -1);
    // INCR write with gaps, half-word strobes
    exp_wr.push_back({4'd2, 32'h11110000, 4'h3});
    exp_wr.push_back({4'd3, 32'h11110001, 4'h3});
    exp_wr.push_back({4'd4, 32'h11110002, 4'h3});
    exp_wr.push_back({4'd5, 32'h11110003, 4'h3});
    exp_b.push_back({12'h021, RESP_OKAY});
    do_write(12'h021, 32'h08, 4'd3, BURST_INCR, 32'h11110000, 4'h3, 2, 3);
    // FIXED read of index 4 with a 3-cycle stall on beat 2
    repeat (3) exp_ra.push_back(4'd4);
    exp_r.push_back({12'h033, 32'hA5A50002, RESP_OKAY, 1'b0});
    exp_r.push_back({12'h033, 32'hA5A50002, RESP_OKAY, 1'b0});
    exp_r.push_back({12'h033, 32'hA5A50002, RESP_OKAY, 1'b1});
    do_read(12'h033, 32'h10, 4'd2, BURST_FIXED, 1);
    // INCR read running past NREGS
    exp_ra.push_back(4'd4); exp_ra.push_back(4'd5); exp_ra.push_back(4'd6); exp_ra.push_back(4'd7);
    exp_r.push_back({12'h044, 32'hA5A50002, RESP_OKAY, 1'b0});
    exp_r.push_back({12'h044, 32'hA5A50003, RESP_OKAY, 1'b0});
    exp_r.push_back({12'h044, 32'h00000000, RESP_SLVERR, 1'b0});
    exp_r.push_back({12'h044, 32'h00000000, RESP_SLVERR, 1'b1});
    do_read(12'h044, 32'h10, 4'd3, BURST_INCR, -1);
    // readback of partially strobed index 3
    exp_ra.push_back(4'd3);
    exp_r.push_back({12'h045, 32'hDEAD0001, RESP_OKAY, 1'b1});
    do_read(12'h045, 32'h0C, 4'd0, BURST_INCR, -1);
    // write above the index field: no register write
    exp_b.push_back({12'h055, RESP_SLVERR});
    do_write(12'h055, 32'h1000, 4'd0, BURST_INCR, 32'h0BAD0BAD, 4'hF, 0, 0);
    // early wlast, then missing wlast
    for (int i = 0; i < 4; i++) exp_wr.push_back({4'(i), 32'h60 + 32'(i), 4'hF});
    exp_b.push_back({12'h066, RESP_SLVERR});
    do_write(12'h066, 32'h00, 4'd3, BURST_INCR, 32'h60, 4'hF, 0, 1);
    for (int i = 0; i < 4; i++) exp_wr.push_back({4'd0, 32'h70 + 32'(i), 4'hF});
    exp_b.push_back({12'h067, RESP_SLVERR});
    do_write(12'h067, 32'h00, 4'd3, BURST_FIXED, 32'h70, 4'hF, 0, -1);
    // concurrent write to 0..3 and FIXED read of 5
    for (int i = 0; i < 4; i++) exp_wr.push_back({4'(i), 32'h80 + 32'(i), 4'hF});
    exp_b.push_back({12'h077, RESP_OKAY});
    repeat (4) exp_ra.push_back(4'd5);
    for (int i = 0; i < 4; i++) exp_r.push_back({12'h078, 32'hA5A50003, RESP_OKAY, i == 3});
    fork
      do_write(12'h077, 32'h00, 4'd3, BURST_INCR, 32'h80, 4'hF, 0, 3);
      do_read(12'h078, 32'h14, 4'd3, BURST_FIXED, -1);
    join
    // reset in the middle of concurrent bursts
    mon_en = 0;
    s_awvalid = 1; s_awid = 12'h099; s_awaddr = 0; s_awlen = 4'd3; s_awburst = BURST_INCR;
    s_arvalid = 1; s_arid = 12'h09A; s_araddr = 0; s_arlen = 4'd3; s_arburst = BURST_INCR;
    @(posedge clk); #1 s_awvalid = 0; s_arvalid = 0;
    s_wvalid = 1; s_wdata = 32'hCAFE0000; s_wstrb = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1; s_wvalid = 0;
    @(posedge clk); #1;
    check_reset("mid");
    mon_en = 1;
    exp_wr.push_back({4'd1, 32'h12345678, 4'hF});
    exp_b.push_back({12'h0AB, RESP_OKAY});
    do_write(12'h0AB, 32'h04, 4'd0, BURST_INCR, 32'h12345678, 4'hF, 0, 0);
    exp_ra.push_back(4'd1);
    exp_r.push_back({12'h0AC, 32'h12345678, RESP_OKAY, 1'b1});
    do_read(12'h0AC, 32'h04, 4'd0, BURST_INCR, -1);
    repeat (4) @(posedge clk);
    chk("exp_wr_left", 64'(exp_wr.size()), 0);
    chk("exp_ra_left", 64'(exp_ra.size()), 0);
    chk("exp_b_left", 64'(exp_b.size()), 0);
    chk("exp_r_left", 64'(exp_r.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
